// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: datapath width, reset/NOP defaults and
// the fetch-stage state encoding.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_FETCH = 2'd0;
  localparam fetch_state_t S_WAIT  = 2'd1;
  localparam fetch_state_t S_HOLD  = 2'd2;
  localparam fetch_state_t S_FAULT = 2'd3;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline slot. Priority: flush > load > hold > bubble.
module ifid_reg
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_hold,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_misalign,
  output logic            o_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4,
  output logic            o_misalign
);

  logic            r_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic            r_misalign;

  // Bubbles and flushes keep id_pc/id_pc4 to avoid needless toggling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_inst     <= NOP_INST;
      r_pc       <= '0;
      r_pc4      <= 32'd4;
      r_misalign <= 1'b0;
    end else if (i_flush || (!i_load && !i_hold)) begin
      r_valid    <= 1'b0;
      r_inst     <= NOP_INST;
      r_misalign <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_inst     <= i_inst;
      r_pc       <= i_pc;
      r_pc4      <= pc_plus4(i_pc);
      r_misalign <= i_misalign;
    end
  end

  assign o_valid    = r_valid;
  assign o_inst     = r_inst;
  assign o_pc       = r_pc;
  assign o_pc4      = r_pc4;
  assign o_misalign = r_misalign;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem handshake, 1-entry
// response buffer and IF/ID slot. FETCH_MISALIGN_CHECK_EN adds the FAULT state.
//
// state   | meaning
// FETCH   | issue a request for pc (suppressed during a redirect)
// WAIT    | request outstanding; kill marks its response as stale
// HOLD    | response parked in the buffer while the slot is stalled
// FAULT   | misaligned redirect target presented in the slot until redirected
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic            id_misalign
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic [XLEN-1:0] r_buf;

  logic            w_free;
  logic            w_bad_tgt;
  logic            w_outstanding;
  logic            w_take;
  logic            w_drain;
  logic            w_slot_load;
  logic            w_slot_flush;
  logic            w_slot_hold;
  logic [XLEN-1:0] w_slot_inst;
  logic [XLEN-1:0] w_slot_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_bad_tgt = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_bad_tgt = 1'b0;
`endif

  assign w_free        = !id_valid || !id_stall;
  // A misaligned redirect out of WAIT leaves the response in flight inside FAULT.
  assign w_outstanding = (r_state == S_WAIT) || ((r_state == S_FAULT) && r_kill);
  assign w_take        = (r_state == S_WAIT) && imem_rvalid && !r_kill && w_free && !redirect_valid;
  assign w_drain       = (r_state == S_HOLD) && w_free && !redirect_valid;

  assign w_slot_load  = w_take || w_drain || w_bad_tgt;
  assign w_slot_flush = redirect_valid && !w_bad_tgt;
  assign w_slot_hold  = id_stall || (r_state == S_FAULT);
  assign w_slot_inst  = w_bad_tgt ? NOP_INST : ((r_state == S_HOLD) ? r_buf : imem_rdata);
  assign w_slot_pc    = w_bad_tgt ? redirect_pc : r_pc;

  assign imem_req  = rst_n && (r_state == S_FETCH) && !redirect_valid;
  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_buf   <= NOP_INST;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      if (w_bad_tgt) begin
        r_state <= S_FAULT;
        r_kill  <= w_outstanding && !imem_rvalid;
      end else if (w_outstanding && !imem_rvalid) begin
        r_state <= S_WAIT;
        r_kill  <= 1'b1;
      end else begin
        r_state <= S_FETCH;
        r_kill  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_FETCH;
            end else if (w_free) begin
              r_pc    <= pc_plus4(r_pc);
              r_state <= S_FETCH;
            end else begin
              r_buf   <= imem_rdata;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_free) begin
            r_pc    <= pc_plus4(r_pc);
            r_state <= S_FETCH;
          end
        end
        default: begin
          if (imem_rvalid) r_kill <= 1'b0;
        end
      endcase
    end
  end

  ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (w_slot_flush),
    .i_load     (w_slot_load),
    .i_hold     (w_slot_hold),
    .i_inst     (w_slot_inst),
    .i_pc       (w_slot_pc),
    .i_misalign (w_bad_tgt),
    .o_valid    (id_valid),
    .o_inst     (id_inst),
    .o_pc       (id_pc),
    .o_pc4      (id_pc4),
    .o_misalign (id_misalign)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, then random stall/redirect
// traffic against an instruction-stream scoreboard and a latency-randomised memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_misalign;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_misalign    (id_misalign)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00a0_0113;
    return a ^ 32'h5A5A_0013;
  endfunction

  // memory model and stream scoreboard
  bit          use_model = 0;
  bit          pending = 0;
  int          lat_cnt = 0;
  logic [31:0] paddr = '0;
  bit          model_checks = 0;
  bit          in_fault = 0;
  logic [31:0] exp_pc = '0;
  int          consumed = 0;

  bit          prev_hold = 0;
  bit          prev_flush = 0;
  logic        prev_valid;
  logic [31:0] prev_inst, prev_pc, prev_pc4;

  task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc,
                       input bit tb_rv, input logic [31:0] tb_rd);
    @(negedge clk);
    rst_n          = 1'b1;
    id_stall       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (use_model) begin
      if (pending && lat_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pending     = 0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pending) lat_cnt--;
      end
    end else begin
      imem_rvalid = tb_rv;
      imem_rdata  = tb_rd;
    end
    #1;
    if (model_checks) begin
      if (prev_hold) begin
        chk("stall_hold_valid", id_valid, prev_valid);
        chk("stall_hold_inst", id_inst, prev_inst);
        chk("stall_hold_pc", id_pc, prev_pc);
        chk("stall_hold_pc4", id_pc4, prev_pc4);
      end
      if (prev_flush) begin
        chk("flush_valid", id_valid, 0);
        chk("flush_inst", id_inst, NOP);
        chk("flush_misalign", id_misalign, 0);
      end
      if (redir) chk("no_req_on_redirect", imem_req, 0);
      if (id_valid && !stall && !redir && !in_fault) begin
        chk("stream_pc", id_pc, exp_pc);
        chk("stream_inst", id_inst, mem_word(id_pc));
        chk("stream_pc4", id_pc4, id_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redir) exp_pc = rpc;
    end
    if (use_model && imem_req) begin
      chk("one_outstanding", pending, 0);
      pending = 1;
      paddr   = imem_addr;
      lat_cnt = $urandom_range(0, 2);
    end
    prev_hold  = stall && id_valid && !redir;
    prev_flush = redir && (rpc[1:0] == 2'b00);
    prev_valid = id_valid;
    prev_inst  = id_inst;
    prev_pc    = id_pc;
    prev_pc4   = id_pc4;
  endtask

  typedef struct {
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          rv;
    logic [31:0] rd;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } vec_t;

  function automatic vec_t v(bit stall, bit redir, logic [31:0] rpc, bit rv, logic [31:0] rd,
                             bit req, logic [31:0] addr, bit vld, logic [31:0] inst,
                             logic [31:0] pc, logic [31:0] pc4);
    vec_t r;
    r.stall = stall; r.redir = redir; r.rpc = rpc; r.rv = rv; r.rd = rd;
    r.req = req; r.addr = addr; r.vld = vld; r.inst = inst; r.pc = pc; r.pc4 = pc4;
    return r;
  endfunction

  vec_t tv[26];

  initial begin
    // basic stream, 1-cycle latency
    tv[0]  = v(0, 0, 0,            0, 0,            1, 32'h0,   0, NOP,          0,            0);
    tv[1]  = v(0, 0, 0,            1, 32'h00500093, 0, 0,       0, NOP,          0,            0);
    tv[2]  = v(0, 0, 0,            0, 0,            1, 32'h4,   1, 32'h00500093, 32'h0,        32'h4);
    tv[3]  = v(0, 0, 0,            1, 32'h00a00113, 0, 0,       0, NOP,          0,            0);
    tv[4]  = v(0, 0, 0,            0, 0,            1, 32'h8,   1, 32'h00a00113, 32'h4,        32'h8);
    tv[5]  = v(0, 0, 0,            1, 32'h00300193, 0, 0,       0, NOP,          0,            0);
    // stall while the next response lands in the buffer
    tv[6]  = v(1, 0, 0,            0, 0,            1, 32'hC,   1, 32'h00300193, 32'h8,        32'hC);
    tv[7]  = v(1, 0, 0,            1, 32'h00400213, 0, 0,       1, 32'h00300193, 32'h8,        32'hC);
    tv[8]  = v(1, 0, 0,            0, 0,            0, 0,       1, 32'h00300193, 32'h8,        32'hC);
    tv[9]  = v(1, 0, 0,            0, 0,            0, 0,       1, 32'h00300193, 32'h8,        32'hC);
    tv[10] = v(0, 0, 0,            0, 0,            0, 0,       1, 32'h00300193, 32'h8,        32'hC);
    tv[11] = v(0, 0, 0,            0, 0,            1, 32'h10,  1, 32'h00400213, 32'hC,        32'h10);
    // redirect during WAIT, latency 3, stale response dropped
    tv[12] = v(0, 1, 32'h100,      0, 0,            0, 0,       0, NOP,          0,            0);
    tv[13] = v(0, 0, 0,            0, 0,            0, 0,       0, NOP,          0,            0);
    tv[14] = v(0, 0, 0,            1, 32'hDEADBEEF, 0, 0,       0, NOP,          0,            0);
    tv[15] = v(0, 0, 0,            0, 0,            1, 32'h100, 0, NOP,          0,            0);
    tv[16] = v(0, 0, 0,            1, 32'h00500293, 0, 0,       0, NOP,          0,            0);
    // redirect wins over stall with a valid slot; target exercises wrap
    tv[17] = v(1, 0, 0,            0, 0,            1, 32'h104, 1, 32'h00500293, 32'h100,      32'h104);
    tv[18] = v(1, 1, 32'hFFFFFFFC, 0, 0,            0, 0,       1, 32'h00500293, 32'h100,      32'h104);
    tv[19] = v(0, 0, 0,            1, 32'hCAFEF00D, 0, 0,       0, NOP,          0,            0);
    tv[20] = v(0, 0, 0,            0, 0,            1, 32'hFFFFFFFC, 0, NOP,     0,            0);
    tv[21] = v(0, 0, 0,            1, 32'h00600313, 0, 0,       0, NOP,          0,            0);
    tv[22] = v(0, 0, 0,            0, 0,            1, 32'h0,   1, 32'h00600313, 32'hFFFFFFFC, 32'h0);
    tv[23] = v(0, 0, 0,            1, 32'h00500093, 0, 0,       0, NOP,          0,            0);
    tv[24] = v(0, 0, 0,            0, 0,            1, 32'h4,   1, 32'h00500093, 32'h0,        32'h4);
    tv[25] = v(0, 0, 0,            1, 32'h00a00113, 0, 0,       0, NOP,          0,            0);

    rst_n = 1'b0; id_stall = 0; redirect_valid = 0; redirect_pc = '0;
    imem_rvalid = 0; imem_rdata = '0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    chk("reset_req", imem_req, 0);
    chk("reset_valid", id_valid, 0);
    chk("reset_inst", id_inst, NOP);
    chk("reset_pc", id_pc, 32'h0);
    chk("reset_pc4", id_pc4, 32'h4);
    chk("reset_misalign", id_misalign, 0);

    for (int i = 0; i < 26; i++) begin
      cycle(tv[i].stall, tv[i].redir, tv[i].rpc, tv[i].rv, tv[i].rd);
      chk($sformatf("tv%0d_req", i), imem_req, tv[i].req);
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), id_valid, tv[i].vld);
      chk($sformatf("tv%0d_inst", i), id_inst, tv[i].inst);
      if (tv[i].vld) begin
        chk($sformatf("tv%0d_pc", i), id_pc, tv[i].pc);
        chk($sformatf("tv%0d_pc4", i), id_pc4, tv[i].pc4);
      end
      chk($sformatf("tv%0d_misalign", i), id_misalign, 0);
    end

    // random traffic; the first cycle redirects so the scoreboard has a known start
    use_model    = 1;
    pending      = 0;
    model_checks = 1;
    for (int i = 0; i < 800; i++) begin
      bit          st, rd;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 9) < 3);
      rd  = (i == 0) || ($urandom_range(0, 19) == 0);
      tgt = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
      cycle(st, rd, tgt, 0, 0);
    end
    chk("stream_progress", (consumed > 60) ? 32'd1 : 32'd0, 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
    cycle(0, 1, 32'h0000_0102, 0, 0);
    in_fault = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(i == 1, 0, 0, 0, 0);
      chk("fault_req", imem_req, 0);
      chk("fault_valid", id_valid, 1);
      chk("fault_misalign", id_misalign, 1);
      chk("fault_pc", id_pc, 32'h0000_0102);
      chk("fault_inst", id_inst, NOP);
    end
    cycle(0, 1, 32'h0000_0200, 0, 0);
    in_fault = 0;
    consumed = 0;
    for (int i = 0; i < 60; i++) cycle($urandom_range(0, 3) == 0, 0, 0, 0, 0);
    chk("post_fault_progress", (consumed > 5) ? 32'd1 : 32'd0, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core.
- Owns the PC and issues word fetches to instruction memory over a req/rvalid handshake.
- Registers the returned instruction plus its PC into the IF/ID slot. The decode stage and immediate generator consume that slot.
- Honours the decode stall and the execute-stage redirect (taken branch/jump), which also flushes the slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on id_inst when the slot is empty (addi x0,x0,0).

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- imem_req  output  1  fetch request; memory accepts it in the same cycle it is asserted
- imem_addr  output  32  fetch byte address (= pc), valid when imem_req=1
- imem_rvalid  input  1  response valid; exactly one per accepted request, latency >=1 cycle
- imem_rdata  input  32  instruction word, valid with imem_rvalid
- id_stall  input  1  decode cannot accept; IF/ID slot must hold
- redirect_valid  input  1  EX redirect/flush request
- redirect_pc  input  32  redirect target
- id_valid  output  1  IF/ID slot holds a real instruction
- id_inst  output  32  instruction in the slot
- id_pc  output  32  PC of id_inst
- id_pc4  output  32  id_pc + 4
- id_misalign  output  1  fetch-address-misaligned flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=FETCH, kill=0, buffer empty, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc4=4, id_misalign=0. imem_req is forced 0 while rst_n=0.
- Only one request is outstanding at a time. All adders are 32-bit and wrap mod 2^32 (32'hFFFF_FFFC+4 = 0).
- States:
  - FETCH: imem_req = !redirect_valid; imem_addr = pc. Goes to WAIT when a request is issued.
  - WAIT: imem_req=0. Waits for imem_rvalid.
  - HOLD: a response has been received into a 1-entry buffer, but the IF/ID slot was stalled.
- Slot-free condition: free = !id_valid || !id_stall.
- WAIT, on rvalid with kill=1: drop the data, clear kill, go to FETCH. pc is already the redirect target.
- WAIT, on rvalid with kill=0 and free: load the slot (id_valid=1, id_inst=rdata, id_pc=pc, id_pc4=pc+4), set pc=pc+4, go to FETCH.
- WAIT, on rvalid with kill=0 and !free: capture rdata into the buffer and go to HOLD.
- HOLD with free: move the buffer into the slot, set pc=pc+4, go to FETCH.
- Slot with id_stall=0 and no new instruction this cycle: id_valid<=0 and id_inst<=NOP_INST (bubble).
- Slot with id_stall=1: hold all id_* unchanged.
- Redirect (highest priority, overrides stall):
  - pc<=redirect_pc; id_valid<=0, id_inst<=NOP_INST; buffer dropped.
  - From WAIT: stay in WAIT with kill<=1. If rvalid arrives in the same cycle, that response is discarded and the next state is FETCH with kill=0.
  - From FETCH or HOLD: go to FETCH. No request is issued in the redirect cycle.
- Steady-state throughput is 1 instruction per 2 cycles at 1-cycle memory latency. Wider issue is not a goal.
- Reset asserted mid-WAIT: state returns to FETCH. The memory side is reset alongside the core, so no stale response is expected.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect whose target has redirect_pc[1:0]!=0 still loads pc, then goes to state FAULT instead of issuing a fetch.
  - FAULT presents the slot as id_valid=1, id_misalign=1, id_inst=NOP_INST, id_pc=faulting pc.
  - FAULT holds until the next redirect_valid.
- Undefined: no FAULT state, id_misalign tied 0, and the low PC bits pass through to imem_addr unchanged.

Decomposition:
- Shared package rv32_pkg holds:
  - NOP_INST and RESET_PC defaults
  - fetch state enum {FETCH, WAIT, HOLD, FAULT}
  - XLEN=32
- One sub-module, ifid_reg: the IF/ID slot register with load, hold and flush priority. The FSM, PC and buffer stay in fetch_stage.

Test Plan:
1. Reset then run with 1-cycle memory returning 32'h00500093 at 0 and 32'h00a00113 at 4, no stall.
   - Expect: imem_addr 0, then 4.
   - Expect: id_inst/id_pc = 00500093/0, then 00a00113/4, with id_pc4 = 4 and 8.
2. Assert id_stall for 3 cycles while a response arrives.
   - Expect: state HOLD; id_* unchanged throughout.
   - On release, the buffered word enters the slot with the correct id_pc and pc advances by 4.
3. Redirect to 32'h0000_0100 during WAIT with memory latency 3.
   - Expect: the stale response is discarded and id_valid=0.
   - Expect: the next imem_addr is 32'h100.
4. redirect_valid together with id_stall=1 and id_valid=1.
   - Expect: slot flushed (id_valid=0, id_inst=NOP_INST); redirect wins.
5. pc=32'hFFFF_FFFC fetch.
   - Expect: id_pc4=0 and the next imem_addr=0.
6. With FETCH_MISALIGN_CHECK_EN defined, redirect to 32'h0000_0102.
   - Expect: no imem_req; id_valid=1, id_misalign=1, id_pc=32'h102.
   - Expect: a following redirect to 32'h200 clears the fault.
